// File: rtl/riscv_i32_fetch_pkg.sv
// Shared types for the RISC-V instruction fetch request/response interface.
package riscv_i32_fetch_pkg;

  localparam logic [2:0] RISCV_MODE_DEBUG = 3'h7;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic        sequential;
    logic [2:0]  mode;
    logic        predicted_branch;
    logic [31:0] pc_if_mispredicted;
    logic        flush_pipeline;
  } t_ifetch_req;

  typedef struct packed {
    logic        valid;
    logic        debug;
    logic [31:0] data;
    logic [2:0]  mode;
    logic        error;
    logic [1:0]  tag;
  } t_ifetch_resp;

  typedef enum logic {
    IDLE,
    SECOND
  } t_fetch_state;

  typedef enum logic [1:0] {
    RESP_SRAM,
    RESP_MERGE,
    RESP_ERROR
  } t_resp_sel;

endpackage

// File: rtl/riscv_i32_ifetch_line_buffer.sv
// One-word line buffer for the fetch responder. Tag and valid update when a read is
// issued so back-to-back lookups see it; the word itself lands when the SRAM returns it.
module riscv_i32_ifetch_line_buffer
  import riscv_i32_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alloc,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  fill,
  input  logic [31:0]           fill_data,
  input  logic                  invalidate,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [31:0]           line_data
);

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [31:0]           buf_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      // an invalidate in the same cycle as an allocation leaves the buffer empty
      if (invalidate) begin
        buf_valid <= 1'b0;
      end else if (alloc) begin
        buf_valid <= 1'b1;
      end
      if (alloc) begin
        buf_addr <= alloc_addr;
      end
      if (fill) begin
        buf_data <= fill_data;
      end
    end
  end

  assign hit       = buf_valid && (buf_addr == lookup_addr);
  assign line_data = buf_data;

endmodule

// File: rtl/riscv_i32_ifetch_sram_responder.sv
// Serves 32-bit RISC-V fetches at any halfword address from a 1-cycle-latency SRAM,
// using a one-word line buffer so sequential misaligned fetches need a single read.
module riscv_i32_ifetch_sram_responder
  import riscv_i32_fetch_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ifetch_req__valid,
  input  logic [31:0]                ifetch_req__address,
  input  logic                       ifetch_req__sequential,
  input  logic [2:0]                 ifetch_req__mode,
  input  logic                       ifetch_req__predicted_branch,
  input  logic [31:0]                ifetch_req__pc_if_mispredicted,
  input  logic                       ifetch_req__flush_pipeline,
  input  logic                       buffer_invalidate,
  output logic                       ifetch_resp__valid,
  output logic                       ifetch_resp__debug,
  output logic [31:0]                ifetch_resp__data,
  output logic [2:0]                 ifetch_resp__mode,
  output logic                       ifetch_resp__error,
  output logic [1:0]                 ifetch_resp__tag,
  output logic                       sram_read_enable,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_address,
  input  logic [31:0]                sram_read_data
);

  localparam int AW = SRAM_ADDR_WIDTH;

  t_ifetch_req  req;
  t_ifetch_resp resp;

  t_fetch_state state, state_next;
  t_resp_sel    resp_sel, resp_sel_next;
  logic         resp_pending, resp_pending_next;
  logic [2:0]   resp_mode, resp_mode_next;
  logic [AW-1:0] sec_word, sec_word_next;
  logic         fill_pending;

  logic          read_enable;
  logic [AW-1:0] read_addr;
  logic          alloc;
  logic [AW-1:0] alloc_addr;
  logic          drop;
  logic          hit;
  logic [31:0]   line_data;

  logic [AW-1:0] word;
  logic [AW-1:0] word_inc;
  logic          misaligned;
  logic          fault;
  logic          unused_bits;

  assign req = '{
    valid:              ifetch_req__valid,
    address:            ifetch_req__address,
    sequential:         ifetch_req__sequential,
    mode:               ifetch_req__mode,
    predicted_branch:   ifetch_req__predicted_branch,
    pc_if_mispredicted: ifetch_req__pc_if_mispredicted,
    flush_pipeline:     ifetch_req__flush_pipeline
  };

  assign word       = req.address[AW+1:2];
  assign word_inc   = word + AW'(1);
  assign misaligned = req.address[1];
  // a misaligned fetch of the last word would need the word past the end of the SRAM
  assign fault      = req.address[0] | (|req.address[31:AW+2]) | (misaligned & (&word));

  assign unused_bits = ^{req.sequential, req.predicted_branch, req.pc_if_mispredicted,
                         req.flush_pipeline, line_data[15:0]};

  always_comb begin
    state_next        = state;
    resp_pending_next = 1'b0;
    resp_sel_next     = resp_sel;
    resp_mode_next    = resp_mode;
    sec_word_next     = sec_word;
    read_enable       = 1'b0;
    read_addr         = word;
    alloc             = 1'b0;
    alloc_addr        = word;
    drop              = 1'b0;

    unique case (state)
      IDLE: begin
        if (req.valid) begin
          resp_mode_next = req.mode;
          if (fault) begin
            resp_pending_next = 1'b1;
            resp_sel_next     = RESP_ERROR;
          end else if (!misaligned) begin
            read_enable       = 1'b1;
            alloc             = 1'b1;
            resp_pending_next = 1'b1;
            resp_sel_next     = RESP_SRAM;
          end else if (hit) begin
            read_enable       = 1'b1;
            read_addr         = word_inc;
            alloc             = 1'b1;
            alloc_addr        = word_inc;
            resp_pending_next = 1'b1;
            resp_sel_next     = RESP_MERGE;
          end else begin
            read_enable   = 1'b1;
            alloc         = 1'b1;
            sec_word_next = word_inc;
            state_next    = SECOND;
          end
        end
      end
      SECOND: begin
        state_next = IDLE;
        if (req.valid) begin
          read_enable       = 1'b1;
          read_addr         = sec_word;
          alloc             = 1'b1;
          alloc_addr        = sec_word;
          resp_pending_next = 1'b1;
          resp_sel_next     = RESP_MERGE;
        end else begin
          drop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      resp_pending <= 1'b0;
      resp_sel     <= RESP_SRAM;
      resp_mode    <= '0;
      sec_word     <= '0;
      fill_pending <= 1'b0;
    end else begin
      state        <= state_next;
      resp_pending <= resp_pending_next;
      resp_sel     <= resp_sel_next;
      resp_mode    <= resp_mode_next;
      sec_word     <= sec_word_next;
      fill_pending <= read_enable;
    end
  end

  riscv_i32_ifetch_line_buffer #(
    .ADDR_WIDTH(AW)
  ) u_line_buffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .alloc       (alloc),
    .alloc_addr  (alloc_addr),
    .fill        (fill_pending),
    .fill_data   (sram_read_data),
    .invalidate  (buffer_invalidate | drop),
    .lookup_addr (word),
    .hit         (hit),
    .line_data   (line_data)
  );

  assign sram_read_enable = read_enable & reset_n;
  assign sram_address     = read_addr;

  always_comb begin
    resp       = '0;
    resp.valid = resp_pending;
    if (resp_pending) begin
      resp.mode  = resp_mode;
      resp.debug = (resp_mode == RISCV_MODE_DEBUG);
      unique case (resp_sel)
        RESP_SRAM:  resp.data  = sram_read_data;
        RESP_MERGE: resp.data  = {sram_read_data[15:0], line_data[31:16]};
        RESP_ERROR: resp.error = 1'b1;
        default:    resp.error = 1'b1;
      endcase
    end
  end

  assign ifetch_resp__valid = resp.valid;
  assign ifetch_resp__debug = resp.debug;
  assign ifetch_resp__data  = resp.data;
  assign ifetch_resp__mode  = resp.mode;
  assign ifetch_resp__error = resp.error;
  assign ifetch_resp__tag   = resp.tag;

endmodule

// File: tb/tb_riscv_i32_ifetch_sram_responder.sv
// Scoreboard bench for the fetch responder: a halfword-addressed memory model predicts each
// response, a monitor compares whatever the DUT presents against the queue of predictions.
module tb_riscv_i32_ifetch_sram_responder;

  localparam int AW    = 14;
  localparam int RANGE = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ifetch_req__valid;
  logic [31:0]   ifetch_req__address;
  logic          ifetch_req__sequential;
  logic [2:0]    ifetch_req__mode;
  logic          ifetch_req__predicted_branch;
  logic [31:0]   ifetch_req__pc_if_mispredicted;
  logic          ifetch_req__flush_pipeline;
  logic          buffer_invalidate;
  logic          ifetch_resp__valid;
  logic          ifetch_resp__debug;
  logic [31:0]   ifetch_resp__data;
  logic [2:0]    ifetch_resp__mode;
  logic          ifetch_resp__error;
  logic [1:0]    ifetch_resp__tag;
  logic          sram_read_enable;
  logic [AW-1:0] sram_address;
  logic [31:0]   sram_read_data = 32'h0;

  always #5 clk = ~clk;

  riscv_i32_ifetch_sram_responder #(
    .SRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .ifetch_req__valid              (ifetch_req__valid),
    .ifetch_req__address            (ifetch_req__address),
    .ifetch_req__sequential         (ifetch_req__sequential),
    .ifetch_req__mode               (ifetch_req__mode),
    .ifetch_req__predicted_branch   (ifetch_req__predicted_branch),
    .ifetch_req__pc_if_mispredicted (ifetch_req__pc_if_mispredicted),
    .ifetch_req__flush_pipeline     (ifetch_req__flush_pipeline),
    .buffer_invalidate              (buffer_invalidate),
    .ifetch_resp__valid             (ifetch_resp__valid),
    .ifetch_resp__debug             (ifetch_resp__debug),
    .ifetch_resp__data              (ifetch_resp__data),
    .ifetch_resp__mode              (ifetch_resp__mode),
    .ifetch_resp__error             (ifetch_resp__error),
    .ifetch_resp__tag               (ifetch_resp__tag),
    .sram_read_enable               (sram_read_enable),
    .sram_address                   (sram_address),
    .sram_read_data                 (sram_read_data)
  );

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (sram_read_enable) sram_read_data <= mem[sram_address];
  end

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [2:0]  mode;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] prev_addr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[AW+1:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // memory viewed as a halfword array: a fetch is the two halfwords at a and a+2
  function automatic exp_t model(input logic [31:0] a, input logic [2:0] m);
    exp_t e;
    e.mode = m;
    if (a[0] || (longint'(a) + 64'sd4 > longint'(RANGE))) begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end else begin
      e.err  = 1'b0;
      e.data = {half_at(a + 32'd2), half_at(a)};
    end
    return e;
  endfunction

  // monitor: every presented response must match the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && ifetch_resp__valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(ifetch_resp__valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("resp", {25'h0, ifetch_resp__debug, ifetch_resp__error, ifetch_resp__tag,
                         ifetch_resp__mode, ifetch_resp__data},
                        {25'h0, (e.mode == 3'h7), e.err, 2'b00, e.mode, e.data});
        end
      end
    end
  end

  // called at a negedge; returns at the negedge of the response cycle
  // lat_req 0 means a misaligned fetch where either one or two cycles is acceptable
  task automatic issue(input logic [31:0] a, input logic [2:0] m, input int lat_req);
    exp_t e;
    int   lat;
    e = model(a, m);
    exp_q.push_back(e);
    ifetch_req__valid              = 1'b1;
    ifetch_req__address            = a;
    ifetch_req__mode               = m;
    ifetch_req__sequential         = (a == prev_addr + 32'd4);
    ifetch_req__predicted_branch   = 1'($urandom);
    ifetch_req__pc_if_mispredicted = $urandom;
    ifetch_req__flush_pipeline     = 1'($urandom);
    prev_addr = a;
    #1;
    if (e.err) check("fault_no_sram_read", 64'(sram_read_enable), 64'(0));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ifetch_resp__valid !== 1'b1 && lat < 6);
    if (ifetch_resp__valid !== 1'b1) begin
      check("resp_timeout", 64'(ifetch_resp__valid), 64'(1));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (lat_req != 0) begin
      check("latency", 64'(lat), 64'(lat_req));
    end else begin
      check("latency_range", 64'(lat == 1 || (lat == 2 && !e.err && a[1])), 64'(1));
    end
  endtask

  task automatic idle(input int n);
    ifetch_req__valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_invalidate();
    ifetch_req__valid = 1'b0;
    buffer_invalidate = 1'b1;
    @(negedge clk);
    buffer_invalidate = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    reset_n                        = 1'b0;
    ifetch_req__valid              = 1'b0;
    ifetch_req__address            = 32'h0;
    ifetch_req__sequential         = 1'b0;
    ifetch_req__mode               = 3'h0;
    ifetch_req__predicted_branch   = 1'b0;
    ifetch_req__pc_if_mispredicted = 32'h0;
    ifetch_req__flush_pipeline     = 1'b0;
    buffer_invalidate              = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check("in_reset", {23'h0, ifetch_resp__valid, ifetch_resp__debug, ifetch_resp__error,
                       ifetch_resp__tag, ifetch_resp__mode, ifetch_resp__data, sram_read_enable}, 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle", {23'h0, ifetch_resp__valid, ifetch_resp__debug, ifetch_resp__error,
                           ifetch_resp__tag, ifetch_resp__mode, ifetch_resp__data, sram_read_enable}, 64'h0);
    end

    mem[14'h40] = 32'hDEADBEEF;
    issue(32'h100, 3'h0, 1);
    idle(2);

    mem[14'h40] = 32'h11112222;
    mem[14'h41] = 32'h33334444;
    pulse_invalidate();
    issue(32'h102, 3'h1, 2);
    idle(1);
    issue(32'h106, 3'h2, 1);
    idle(1);

    issue(32'h101, 3'h3, 1);
    issue(32'(RANGE), 3'h4, 1);
    issue(32'(RANGE - 2), 3'h5, 1);
    issue(32'(RANGE - 4), 3'h6, 1);
    idle(1);

    // abandon a cold misaligned fetch in its second cycle
    ifetch_req__valid   = 1'b1;
    ifetch_req__address = 32'h302;
    ifetch_req__mode    = 3'h2;
    @(posedge clk);
    #1;
    ifetch_req__valid = 1'b0;
    #1;
    check("abandon_no_read", 64'(sram_read_enable), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abandon_no_resp", 64'(ifetch_resp__valid), 64'(0));
    end
    issue(32'h302, 3'h2, 2);
    idle(1);

    issue(32'h100, 3'h0, 1);
    idle(1);
    issue(32'h102, 3'h0, 1);
    idle(1);
    issue(32'h100, 3'h7, 1);
    pulse_invalidate();
    issue(32'h102, 3'h7, 2);
    idle(1);

    // reset while a misaligned fetch is in its second cycle
    ifetch_req__valid   = 1'b1;
    ifetch_req__address = 32'h402;
    ifetch_req__mode    = 3'h1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_abort", {62'h0, ifetch_resp__valid, sram_read_enable}, 64'h0);
    ifetch_req__valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_abort_no_resp", 64'(ifetch_resp__valid), 64'(0));
    end
    issue(32'h402, 3'h1, 2);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)       a = prev_addr + 32'd4;
      else if (r < 80)  a = 32'h100 + 32'($urandom_range(0, 63)) * 2;
      else if (r < 88)  a = 32'($urandom_range(0, RANGE / 2 - 1)) * 2;
      else if (r < 93)  a = 32'h101 + 32'($urandom_range(0, 63)) * 2;
      else if (r < 97)  a = 32'(RANGE) + 32'($urandom_range(0, 1023)) * 2;
      else              a = 32'(RANGE - 2);
      issue(a, 3'($urandom_range(0, 7)), (a[0] || !a[1] || a >= 32'(RANGE - 2)) ? 1 : 0);
      if ($urandom_range(0, 1) == 1) begin
        ifetch_req__valid = 1'b0;
        if ($urandom_range(0, 9) == 0) begin
          mem[14'($urandom_range(32'h40, 32'h60))] = $urandom;
          pulse_invalidate();
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
